dp_issue_arbiter: RTL

Round-robin issue controller that shares a single fixed-latency 8-bit processing datapath between `NREQ` requesters. It accepts one request per cycle over valid/ready handshakes and registers the granted request's data and address onto the datapath inputs. It tracks each in-flight operation with a requester tag and steers the datapath result back to the originating requester after the fixed pipeline latency. It sits directly in front of the datapath in the core clock domain.

---
 rtl/dp_issue_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dp_issue_arbiter.sv
// dp_issue_arbiter
//
// Round-robin issue controller that shares one fixed-latency 8-bit datapath
// between NREQ requesters. One request is accepted per cycle. The granted
// operand and address are registered onto the datapath inputs. A tag pipeline
// follows each in-flight operation, so the result can be steered back to the
// requester that issued it.
//
// Parameters
//   NREQ  : number of requesters (2..8)
//   LAT   : datapath latency in clock edges, input register to dp_data_out (>=1)
//   BURST : maximum consecutive grants to one requester while others wait (1..15)
//
// Ports
//   clk, rst_n   : core clock and asynchronous active-low reset
//   req_valid    : per-requester request pending
//   req_data     : per-requester 8-bit operand, slice i = [8i+7:8i]
//   req_addr     : per-requester 4-bit address, slice i = [4i+3:4i]
//   req_ready    : one-hot grant (or zero); a transfer is valid & ready
//   dp_data_in   : registered operand to the datapath
//   dp_addr_in   : registered address to the datapath (0 = no-op)
//   dp_data_out  : datapath result
//   rsp_valid    : one-hot pulse marking the result owner
//   rsp_data     : result data, meaningful while rsp_valid is nonzero
//   busy         : issue register or any tag stage occupied
//   stat_issued  : saturating count of accepted requests

module dp_issue_arbiter #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [8*NREQ-1:0]     req_data,
  input  logic [4*NREQ-1:0]     req_addr,
  output logic [NREQ-1:0]       req_ready,
  output logic [7:0]            dp_data_in,
  output logic [3:0]            dp_addr_in,
  input  logic [7:0]            dp_data_out,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  busy,
  output logic [15:0]           stat_issued
);

  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  BURST_L = 4'(BURST);
  localparam logic [TW:0] NREQ_L  = (TW + 1)'(NREQ);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [TW-1:0]   owner;
  logic [TW-1:0]   rr_ptr;
  logic [3:0]      burst_cnt;

  logic            others_valid;
  logic            keep_owner;
  logic            rr_found;
  logic [TW-1:0]   rr_idx;
  logic [TW:0]     cand;
  logic            grant_any;
  logic [TW-1:0]   grant_idx;
  logic            transfer;
  logic [7:0]      sel_data;
  logic [3:0]      sel_addr;

  logic            issue_vld;
  logic [LAT:0]    stg_vld;
  logic [TW-1:0]   stg_tag [LAT+1];

  // Grant selection. The current owner keeps the datapath until its burst
  // allowance is used up, but only while someone else is actually waiting;
  // a lone requester streams indefinitely. Otherwise the search starts one
  // past the last new grant, so the previous winner is considered last.
  always_comb begin
    others_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if ((TW'(i) != owner) && req_valid[i]) others_valid = 1'b1;
    end

    keep_owner = (state == OWN) && req_valid[owner] &&
                 ((burst_cnt < BURST_L) || !others_valid);

    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (TW + 1)'(k);
      if (cand >= NREQ_L) cand = cand - NREQ_L;
      if (!rr_found && req_valid[cand[TW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[TW-1:0];
      end
    end

    grant_any = keep_owner || rr_found;
    grant_idx = keep_owner ? owner : rr_idx;
  end

  // Ready is gated by rst_n so nothing appears granted while reset is held,
  // even though the selection logic itself is purely combinational.
  always_comb begin
    req_ready = '0;
    if (rst_n && grant_any) req_ready = NREQ'(1) << grant_idx;
    transfer = |(req_valid & req_ready);
  end

  // Operand and address of the granted requester.
  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (TW'(i) == grant_idx) begin
        sel_data = req_data[8*i +: 8];
        sel_addr = req_addr[4*i +: 4];
      end
    end
  end

  // Ownership FSM. A cycle without any transfer drops ownership, but rr_ptr
  // remembers the last new winner so fairness survives idle gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= TW'(NREQ - 1);
      burst_cnt <= '0;
    end else if (transfer) begin
      if (keep_owner) begin
        if (burst_cnt < BURST_L) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        state     <= OWN;
        owner     <= grant_idx;
        rr_ptr    <= grant_idx;
        burst_cnt <= 4'd1;
      end
    end else begin
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end

  // Issue register. Idle cycles drive the all-zero no-op address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_data_in <= '0;
      dp_addr_in <= '0;
      issue_vld  <= 1'b0;
    end else begin
      dp_data_in <= transfer ? sel_data : 8'd0;
      dp_addr_in <= transfer ? sel_addr : 4'd0;
      issue_vld  <= transfer;
    end
  end

  // Tag pipeline, one stage longer than the datapath latency so that the
  // last stage lines up with the result on dp_data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      for (int i = 0; i <= LAT; i++) stg_tag[i] <= '0;
    end else begin
      stg_vld    <= {stg_vld[LAT-1:0], transfer};
      stg_tag[0] <= grant_idx;
      for (int i = 1; i <= LAT; i++) stg_tag[i] <= stg_tag[i-1];
    end
  end

  // Saturating issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
    end else if (transfer && (stat_issued != 16'hFFFF)) begin
      stat_issued <= stat_issued + 16'd1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (stg_vld[LAT]) rsp_valid = NREQ'(1) << stg_tag[LAT];
    rsp_data = dp_data_out;
    busy     = issue_vld || (|stg_vld);
  end

endmodule
